tensor_core_instruction_sequencer: RTL
======================================

TENSOR_CORE_INSTRUCTION_SEQUENCER -- requirements
Module: tensor_core_instruction_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 16: instruction word width.
REQ-002 SHALL have parameter DEPTH, default 256: program memory entries, power of two; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter LOOP_WIDTH, default 8: width of the repeat counter.
REQ-004 SHALL have parameter HALT_INSTRUCTION, default 16'hFFFF (INSTR_WIDTH bits): word that ends a program early.
REQ-005 SHALL have port clock_in, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port power_on_reset_signal_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port load_enable, input, 1: write load_data into program memory at load_address.
REQ-008 SHALL have port load_address, input, AW: program memory write address.
REQ-009 SHALL have port load_data, input, INSTR_WIDTH: program memory write data.
REQ-010 SHALL have port start, input, 1: begin execution (level, sampled in IDLE).
REQ-011 SHALL have port program_length, input, AW+1: number of instructions per pass, sampled at start.
REQ-012 SHALL have port loop_count, input, LOOP_WIDTH: extra passes (total passes = loop_count+1), sampled at start.
REQ-013 SHALL have port abort, input, 1: terminate execution.
REQ-014 SHALL have port current_instruction, output, INSTR_WIDTH: instruction to the tensor core controller.
REQ-015 SHALL have port instruction_valid, output, 1: current_instruction is valid.
REQ-016 SHALL have port instruction_ready, input, 1: controller accepts the instruction.
REQ-017 SHALL have port program_counter, output, AW: address of the current/next instruction.
REQ-018 SHALL have port busy, output, 1: high in FETCH and ISSUE.
REQ-019 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, FETCH, ISSUE, DONE.
REQ-021 IDLE: start=1 and program_length!=0 -> FETCH, pc=0, latch length and passes; start with program_length=0 -> DONE directly.
REQ-022 FETCH: exactly one cycle; registered memory read of mem[pc]; -> ISSUE.
REQ-023 ISSUE: instruction_valid = 1 iff fetched word != HALT_INSTRUCTION; current_instruction = fetched word while valid, else all zeros (NOP).
REQ-024 ISSUE with fetched word == HALT_INSTRUCTION: halt word not issued; -> DONE next cycle, remaining passes discarded.
REQ-025 ISSUE, valid and instruction_ready=0: hold state, word and pc stable (no drop, no change).
REQ-026 ISSUE, handshake (valid & ready): if pc == length-1 and remaining passes == 0 -> DONE; if pc == length-1 and passes > 0 -> pc=0, passes-1, FETCH; else pc+1, FETCH.
REQ-027 Throughput: at most one instruction per two cycles; latency start-to-first-valid = 2 cycles.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-029 abort=1 in FETCH/ISSUE/DONE -> IDLE next cycle; valid deasserts next cycle; done not pulsed; abort has priority over handshake.
REQ-030 load_enable honoured only in IDLE; ignored otherwise; simultaneous load and start in IDLE: write performed, execution starts.
REQ-031 start outside IDLE ignored; start held high after DONE restarts from IDLE.
REQ-032 pc arithmetic modulo DEPTH; program_length > DEPTH wraps pc to 0 within a pass.
REQ-033 loop_count = 2^LOOP_WIDTH-1 supported without overflow.

Reset
REQ-034 power_on_reset_signal_n=0 at a rising edge: state IDLE, pc=0, current_instruction=0, instruction_valid=0, busy=0, done=0, counters cleared.
REQ-035 Reset has priority over abort, start and load; mid-run reset drops valid next cycle; program memory contents not cleared.

Verification
REQ-036 Load mem[0..2]=16'h1001,16'h1002,16'h1003, length=3, loop=0, ready=1 -> three handshakes with those words in order, pc 0,1,2, done pulse once, 2 cycles per instruction.
REQ-037 Same program, loop_count=2 -> nine handshakes (sequence repeated 3x), single done pulse after the ninth.
REQ-038 mem[1]=16'hFFFF, length=3 -> only 16'h1001 issued, done pulses, 16'h1003 never valid.
REQ-039 ready held 0 for 5 cycles on the second instruction -> valid high and word 16'h1002 stable all 5 cycles; issued once when ready=1.
REQ-040 abort during ISSUE of instruction 2 -> IDLE next cycle, valid=0, done never pulsed; reset asserted mid-run -> all outputs zero next cycle, memory intact on rerun.

Source files
------------

// File: rtl/tensor_core_instruction_sequencer.sv
// Instruction sequencer for a tensor core: holds a small program memory,
// streams its words to the core controller with a valid/ready handshake,
// supports repeated passes, early halt on a reserved word, and abort.
module tensor_core_instruction_sequencer #(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int LOOP_WIDTH = 8,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTRUCTION = {INSTR_WIDTH{1'b1}},
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clock_in,
  input  logic                   power_on_reset_signal_n,
  input  logic                   load_enable,
  input  logic [AW-1:0]          load_address,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [AW:0]            program_length,
  input  logic [LOOP_WIDTH-1:0]  loop_count,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] current_instruction,
  output logic                   instruction_valid,
  input  logic                   instruction_ready,
  output logic [AW-1:0]          program_counter,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [AW:0]           IDX_ONE  = (AW+1)'(1);
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);

  state_t                 state, next_state;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] word_p1;
  // idx is one bit wider than the address so lengths above DEPTH still
  // terminate correctly while the visible pc wraps modulo DEPTH.
  logic [AW:0]            idx;
  logic [AW:0]            length_r;
  logic [LOOP_WIDTH-1:0]  passes;
  logic                   is_halt;
  logic                   last;
  logic                   handshake;

  assign is_halt   = (word_p1 == HALT_INSTRUCTION);
  assign last      = (idx == (length_r - IDX_ONE));
  assign handshake = (state == ISSUE) && !is_halt && instruction_ready && !abort;

  assign program_counter     = idx[AW-1:0];
  assign instruction_valid   = (state == ISSUE) && !is_halt;
  assign current_instruction = instruction_valid ? word_p1 : '0;
  assign busy                = (state == FETCH) || (state == ISSUE);
  assign done                = (state == DONE) && !abort;

  // Next-state decode; abort outranks both halt and handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (program_length != '0) ? FETCH : DONE;
      end
      FETCH: begin
        next_state = abort ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (abort)                          next_state = IDLE;
        else if (is_halt)                   next_state = DONE;
        else if (instruction_ready)
          next_state = (last && passes == '0) ? DONE : FETCH;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state: FSM register, instruction index and pass counter.
  always_ff @(posedge clock_in) begin
    if (!power_on_reset_signal_n) begin
      state    <= IDLE;
      idx      <= '0;
      length_r <= '0;
      passes   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start && program_length != '0) begin
        idx      <= '0;
        length_r <= program_length;
        passes   <= loop_count;
      end else if (handshake) begin
        if (last) begin
          idx <= '0;
          if (passes != '0) passes <= passes - LOOP_ONE;
        end else begin
          idx <= idx + IDX_ONE;
        end
      end
    end
  end

  // Program memory write port (IDLE only) and registered fetch read.
  always_ff @(posedge clock_in) begin
    if (power_on_reset_signal_n && state == IDLE && load_enable)
      mem[load_address] <= load_data;
    if (state == FETCH)
      word_p1 <= mem[idx[AW-1:0]];
  end

endmodule
